// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/DM memory-port arbiter.
// Counter saturation value is used only when MEM_ARB_PERF_EN is defined.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    localparam logic [31:0] CNT_SAT = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == CNT_SAT) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core masters, the arbiter and ideal_mem.
// The master modport is the environment side (core requesters plus memory read data).
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  if_req_valid;
    logic                  if_req_ready;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_rsp_valid;
    logic [DATA_WIDTH-1:0] if_rdata;

    logic                  dm_req_valid;
    logic                  dm_req_ready;
    logic                  dm_wen;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0] dm_wdata;
    logic                  dm_rsp_valid;
    logic [DATA_WIDTH-1:0] dm_rdata;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ren;
    logic                  mem_wen;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output if_req_valid, if_addr,
        output dm_req_valid, dm_wen, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_req_ready, if_rsp_valid, if_rdata,
        input  dm_req_ready, dm_rsp_valid, dm_rdata,
        input  mem_addr, mem_ren, mem_wen, mem_wdata
    );

    modport slave (
        input  if_req_valid, if_addr,
        input  dm_req_valid, dm_wen, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_req_ready, if_rsp_valid, if_rdata,
        output dm_req_ready, dm_rsp_valid, dm_rdata,
        output mem_addr, mem_ren, mem_wen, mem_wdata
    );

endinterface

// File: rtl/mem_arb_rr_picker.sv
// Two-way round-robin picker: bit 0 = IF, bit 1 = DM.
// On a conflict the master not granted last wins; history resets to DM.
module mem_arb_rr_picker
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output owner_e     last_grant
);

    owner_e last_q;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last_q == OWN_DM) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= OWN_DM;
        end else if (advance && (grant != 2'b00)) begin
            last_q <= grant[0] ? OWN_IF : OWN_DM;
        end
    end

    assign last_grant = last_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one ideal_mem port between IF and DM: IDLE -> ISSUE -> RESP per access.
// Optional performance counters are built when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus,
    output logic [31:0]       perf_if_grants,
    output logic [31:0]       perf_dm_grants,
    output logic [31:0]       perf_conflicts
);

    state_e                state_q, state_d;
    owner_e                owner_q;
    owner_e                last_grant;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wen_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] if_rdata_q;
    logic [DATA_WIDTH-1:0] dm_rdata_q;
    logic [1:0]            grant;
    logic                  accept;

    mem_arb_rr_picker u_picker (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        ({bus.dm_req_valid, bus.if_req_valid}),
        .advance    (accept),
        .grant      (grant),
        .last_grant (last_grant)
    );

    assign accept = (state_q == IDLE) && (grant != 2'b00);

    always_comb begin
        state_d          = state_q;
        bus.if_req_ready = 1'b0;
        bus.dm_req_ready = 1'b0;
        bus.if_rsp_valid = 1'b0;
        bus.dm_rsp_valid = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_ren      = 1'b0;
        bus.mem_wen      = 1'b0;
        bus.mem_wdata    = '0;
        unique case (state_q)
            IDLE: begin
                // Both ready unless the other master holds the grant; held low in reset.
                bus.if_req_ready = rst_n & ~grant[1];
                bus.dm_req_ready = rst_n & ~grant[0];
                if (accept) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Shifting the whole byte address drops bits [1:0] and zero-fills the top.
                bus.mem_addr  = addr_q >> 2;
                bus.mem_ren   = ~wen_q;
                bus.mem_wen   = wen_q;
                bus.mem_wdata = wdata_q;
                state_d       = RESP;
            end
            RESP: begin
                bus.if_rsp_valid = (owner_q == OWN_IF);
                bus.dm_rsp_valid = (owner_q == OWN_DM);
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= OWN_DM;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q <= grant[0] ? OWN_IF : OWN_DM;
                addr_q  <= grant[0] ? bus.if_addr : bus.dm_addr;
                wen_q   <= grant[1] & bus.dm_wen;
                wdata_q <= grant[1] ? bus.dm_wdata : '0;
            end
            if (state_q == ISSUE) begin
                if (owner_q == OWN_IF) begin
                    if_rdata_q <= bus.mem_rdata;
                end else begin
                    dm_rdata_q <= wen_q ? '0 : bus.mem_rdata;
                end
            end
        end
    end

    assign bus.if_rdata = if_rdata_q;
    assign bus.dm_rdata = dm_rdata_q;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] if_cnt_q, dm_cnt_q, conf_cnt_q;
    logic        conflict;

    assign conflict = (state_q == IDLE) && bus.if_req_valid && bus.dm_req_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_cnt_q   <= '0;
            dm_cnt_q   <= '0;
            conf_cnt_q <= '0;
        end else begin
            if (accept && grant[0]) if_cnt_q <= sat_inc(if_cnt_q);
            if (accept && grant[1]) dm_cnt_q <= sat_inc(dm_cnt_q);
            if (conflict) conf_cnt_q <= sat_inc(conf_cnt_q);
        end
    end

    assign perf_if_grants = if_cnt_q;
    assign perf_dm_grants = dm_cnt_q;
    assign perf_conflicts = conf_cnt_q;
`else
    assign perf_if_grants = '0;
    assign perf_dm_grants = '0;
    assign perf_conflicts = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural ideal_mem (async read, sync write).
// Perf-counter expectations follow MEM_ARB_PERF_EN.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_done = 1'b0;
    logic [31:0] perf_if_grants, perf_dm_grants, perf_conflicts;
    logic [31:0] mem [1024];
    int          total = 0;
    int          bad = 0;
    int          n_acc, n_rsp;
    logic        exp_if;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

    mem_port_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .perf_if_grants (perf_if_grants),
        .perf_dm_grants (perf_dm_grants),
        .perf_conflicts (perf_conflicts)
    );

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h1740_0000 + i;
        end else if (bus.mem_wen) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp)
        else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.if_req_valid = 1'b0;
        bus.if_addr      = '0;
        bus.dm_req_valid = 1'b0;
        bus.dm_wen       = 1'b0;
        bus.dm_addr      = '0;
        bus.dm_wdata     = '0;
        tick();
        tick();

        // Reset state
        check("rst_if_ready", {31'd0, bus.if_req_ready}, 32'd0);
        check("rst_dm_ready", {31'd0, bus.dm_req_ready}, 32'd0);
        check("rst_if_rsp", {31'd0, bus.if_rsp_valid}, 32'd0);
        check("rst_dm_rsp", {31'd0, bus.dm_rsp_valid}, 32'd0);
        check("rst_mem_ren", {31'd0, bus.mem_ren}, 32'd0);
        check("rst_mem_wen", {31'd0, bus.mem_wen}, 32'd0);
        check("rst_mem_addr", {22'd0, bus.mem_addr}, 32'd0);
        check("rst_if_rdata", bus.if_rdata, 32'd0);
        check("rst_dm_rdata", bus.dm_rdata, 32'd0);
        init_done = 1'b1;
        rst_n     = 1'b1;
        #1;
        check("idle_if_ready", {31'd0, bus.if_req_ready}, 32'd1);
        check("idle_dm_ready", {31'd0, bus.dm_req_ready}, 32'd1);

        // Test 1: IF read 0x008
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 10'h008;
        #1;
        check("t1_if_ready", {31'd0, bus.if_req_ready}, 32'd1);
        tick();
        bus.if_req_valid = 1'b0;
        check("t1_mem_ren", {31'd0, bus.mem_ren}, 32'd1);
        check("t1_mem_wen", {31'd0, bus.mem_wen}, 32'd0);
        check("t1_mem_addr", {22'd0, bus.mem_addr}, 32'd2);
        check("t1_issue_ready", {31'd0, bus.if_req_ready}, 32'd0);
        check("t1_issue_rsp", {31'd0, bus.if_rsp_valid}, 32'd0);
        tick();
        check("t1_rsp", {31'd0, bus.if_rsp_valid}, 32'd1);
        check("t1_rdata", bus.if_rdata, 32'h1740_0002);
        check("t1_dm_rsp", {31'd0, bus.dm_rsp_valid}, 32'd0);
        check("t1_resp_mem_ren", {31'd0, bus.mem_ren}, 32'd0);
        tick();
        check("t1_rsp_end", {31'd0, bus.if_rsp_valid}, 32'd0);
        check("t1_rdata_hold", bus.if_rdata, 32'h1740_0002);

        // Test 2: DM write 0x040 then read back
        bus.dm_req_valid = 1'b1;
        bus.dm_wen       = 1'b1;
        bus.dm_addr      = 10'h040;
        bus.dm_wdata     = 32'hDEAD_BEEF;
        tick();
        bus.dm_req_valid = 1'b0;
        check("t2_mem_wen", {31'd0, bus.mem_wen}, 32'd1);
        check("t2_mem_ren", {31'd0, bus.mem_ren}, 32'd0);
        check("t2_mem_addr", {22'd0, bus.mem_addr}, 32'd16);
        check("t2_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        tick();
        check("t2_wr_rsp", {31'd0, bus.dm_rsp_valid}, 32'd1);
        check("t2_wr_rdata", bus.dm_rdata, 32'd0);
        check("t2_wen_drop", {31'd0, bus.mem_wen}, 32'd0);
        check("t2_mem16", mem[16], 32'hDEAD_BEEF);
        check("t2_if_rsp", {31'd0, bus.if_rsp_valid}, 32'd0);
        tick();
        bus.dm_req_valid = 1'b1;
        bus.dm_wen       = 1'b0;
        bus.dm_addr      = 10'h043;
        tick();
        bus.dm_req_valid = 1'b0;
        check("t2_rd_addr", {22'd0, bus.mem_addr}, 32'd16);
        tick();
        check("t2_rd_rsp", {31'd0, bus.dm_rsp_valid}, 32'd1);
        check("t2_rd_rdata", bus.dm_rdata, 32'hDEAD_BEEF);
        check("t2_if_rdata_hold", bus.if_rdata, 32'h1740_0002);
        tick();

        // Test 4: reset during ISSUE of a DM write to 0x044
        bus.dm_req_valid = 1'b1;
        bus.dm_wen       = 1'b1;
        bus.dm_addr      = 10'h044;
        bus.dm_wdata     = 32'h0BAD_F00D;
        tick();
        check("t4_issue_wen", {31'd0, bus.mem_wen}, 32'd1);
        rst_n            = 1'b0;
        bus.dm_req_valid = 1'b0;
        #1;
        check("t4_wen_async_drop", {31'd0, bus.mem_wen}, 32'd0);
        check("t4_ready_in_rst", {31'd0, bus.dm_req_ready}, 32'd0);
        tick();
        check("t4_mem17", mem[17], 32'h1740_0011);
        check("t4_no_rsp", {31'd0, bus.dm_rsp_valid}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("t4_idle_ready", {31'd0, bus.dm_req_ready}, 32'd1);
        check("t4_dm_rdata_rst", bus.dm_rdata, 32'd0);
        tick();
        check("t4_no_rsp_after", {31'd0, bus.dm_rsp_valid}, 32'd0);
        check("t4_mem17_after", mem[17], 32'h1740_0011);

        // Test 3: simultaneous requests alternate, IF first after reset
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 10'h00C;
        bus.dm_req_valid = 1'b1;
        bus.dm_wen       = 1'b0;
        bus.dm_addr      = 10'h010;
        for (int r = 0; r < 5; r++) begin
            exp_if = (r % 2 == 0);
            #1;
            check("t3_if_ready", {31'd0, bus.if_req_ready}, {31'd0, exp_if});
            check("t3_dm_ready", {31'd0, bus.dm_req_ready}, {31'd0, ~exp_if});
            tick();
            tick();
            check("t3_if_rsp", {31'd0, bus.if_rsp_valid}, {31'd0, exp_if});
            check("t3_dm_rsp", {31'd0, bus.dm_rsp_valid}, {31'd0, ~exp_if});
            if (exp_if) check("t3_if_rdata", bus.if_rdata, 32'h1740_0003);
            else        check("t3_dm_rdata", bus.dm_rdata, 32'h1740_0004);
            tick();
        end
        bus.if_req_valid = 1'b0;
        bus.dm_req_valid = 1'b0;

        // Test 6: perf counters after 5 conflicting rounds (3 IF, 2 DM grants since reset)
`ifdef MEM_ARB_PERF_EN
        check("t6_conflicts", perf_conflicts, 32'd5);
        check("t6_if_grants", perf_if_grants, 32'd3);
        check("t6_dm_grants", perf_dm_grants, 32'd2);
`else
        check("t6_conflicts_tied", perf_conflicts, 32'd0);
        check("t6_if_grants_tied", perf_if_grants, 32'd0);
        check("t6_dm_grants_tied", perf_dm_grants, 32'd0);
`endif

        // Test 5: IF held valid back to back
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 10'h008;
        n_acc            = 0;
        n_rsp            = 0;
        #1;
        for (int c = 0; c < 9; c++) begin
            if (bus.if_req_valid && bus.if_req_ready) n_acc++;
            if (bus.if_rsp_valid) n_rsp++;
            check("t5_accept", {31'd0, bus.if_req_ready}, {31'd0, (c % 3 == 0)});
            check("t5_rsp", {31'd0, bus.if_rsp_valid}, {31'd0, (c % 3 == 2)});
            tick();
        end
        bus.if_req_valid = 1'b0;
        check("t5_n_accept", n_acc, 32'd3);
        check("t5_n_rsp", n_rsp, 32'd3);
        check("t5_rdata", bus.if_rdata, 32'h1740_0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
